// File: rtl/otter_pkg.sv
// Shared types and constants for the Otter EX operand stage: ALU function codes,
// operand-select encodings and the bubble values loaded into the ID/EX register.
package otter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b1000;
  localparam logic [3:0] ALU_OR      = 4'b0110;
  localparam logic [3:0] ALU_AND     = 4'b0111;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SLL     = 4'b0001;
  localparam logic [3:0] ALU_SRA     = 4'b1101;
  localparam logic [3:0] ALU_SLT     = 4'b0010;
  localparam logic [3:0] ALU_SLTU    = 4'b0011;
  localparam logic [3:0] ALU_LUICOPY = 4'b1001;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_UIMM = 2'd1,
    SRCA_PC   = 2'd2,
    SRCA_ZERO = 2'd3
  } srcA_sel_t;

  // Codes 5-7 are left unnamed on purpose; the operand mux turns them into zero.
  typedef enum logic [2:0] {
    SRCB_RS2  = 3'd0,
    SRCB_IIMM = 3'd1,
    SRCB_SIMM = 3'd2,
    SRCB_PC   = 3'd3,
    SRCB_FOUR = 3'd4
  } srcB_sel_t;

  localparam logic [3:0] BUBBLE_ALU_FUN = ALU_ADD;
  localparam logic       BUBBLE_VALID   = 1'b0;

  function automatic logic addr_hits(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/otter_fwd_mux.sv
// Resolves one source operand against the EX/MEM and MEM/WB write ports.
// The MEM stage holds the youngest result, so it beats WB; x0 is never forwarded.
module otter_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   regdata_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   fwd_data_o
);
  import otter_pkg::*;

  always_comb begin
    fwd_data_o = regdata_i;
    if (addr_i != '0) begin
      if (mem_we_i && (mem_rd_i == addr_i)) begin
        fwd_data_o = mem_data_i;
      end else if (wb_we_i && (wb_rd_i == addr_i)) begin
        fwd_data_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/otter_ex_operand_stage.sv
// ID/EX pipeline register plus the forwarding and operand-select front end of the ALU.
// Also spots load-use hazards, stalling decode for one cycle while a bubble enters EX.
module otter_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm_u,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_imm_s,
  input  logic [1:0]        id_srcA_sel,
  input  logic [2:0]        id_srcB_sel,
  input  logic [3:0]        id_alu_fun,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_we,
  input  logic              id_mem_rd,
  input  logic              flush,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ALU_srcA,
  output logic [XLEN-1:0]   ALU_srcB,
  output logic [3:0]        ALU_FUN,
  output logic [XLEN-1:0]   ex_rs2_fwd,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_mem_rd,
  output logic [XLEN-1:0]   ex_pc
);
  import otter_pkg::*;

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_u_q,    imm_u_d;
  logic [XLEN-1:0]   imm_i_q,    imm_i_d;
  logic [XLEN-1:0]   imm_s_q,    imm_s_d;
  srcA_sel_t         srcA_sel_q, srcA_sel_d;
  logic [2:0]        srcB_sel_q, srcB_sel_d;
  logic [3:0]        alu_fun_q,  alu_fun_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic              reg_we_q,   reg_we_d;
  logic              mem_rd_q,   mem_rd_d;

  logic              hazard;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;

  assign hazard   = valid_q & mem_rd_q & id_valid & addr_hits(rd_q, id_rs1_addr, id_rs2_addr);
  // A flush discards the dependent instruction anyway, so it must not also hold decode.
  assign id_stall = hazard & ~flush & ~RST;

  always_comb begin
    valid_d    = id_valid;
    pc_d       = id_pc;
    rs1_addr_d = id_rs1_addr;
    rs2_addr_d = id_rs2_addr;
    rs1_data_d = id_rs1_data;
    rs2_data_d = id_rs2_data;
    imm_u_d    = id_imm_u;
    imm_i_d    = id_imm_i;
    imm_s_d    = id_imm_s;
    srcA_sel_d = srcA_sel_t'(id_srcA_sel);
    srcB_sel_d = id_srcB_sel;
    alu_fun_d  = id_alu_fun;
    rd_d       = id_rd_addr;
    reg_we_d   = id_reg_we & id_valid;
    mem_rd_d   = id_mem_rd & id_valid;
    if (flush || hazard) begin
      valid_d    = BUBBLE_VALID;
      pc_d       = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_u_d    = '0;
      imm_i_d    = '0;
      imm_s_d    = '0;
      srcA_sel_d = SRCA_RS1;
      srcB_sel_d = SRCB_RS2;
      alu_fun_d  = BUBBLE_ALU_FUN;
      rd_d       = '0;
      reg_we_d   = 1'b0;
      mem_rd_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q    <= BUBBLE_VALID;
      pc_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_u_q    <= '0;
      imm_i_q    <= '0;
      imm_s_q    <= '0;
      srcA_sel_q <= SRCA_RS1;
      srcB_sel_q <= SRCB_RS2;
      alu_fun_q  <= BUBBLE_ALU_FUN;
      rd_q       <= '0;
      reg_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_u_q    <= imm_u_d;
      imm_i_q    <= imm_i_d;
      imm_s_q    <= imm_s_d;
      srcA_sel_q <= srcA_sel_d;
      srcB_sel_q <= srcB_sel_d;
      alu_fun_q  <= alu_fun_d;
      rd_q       <= rd_d;
      reg_we_q   <= reg_we_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  otter_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .addr_i     (rs1_addr_q),
    .regdata_i  (rs1_data_q),
    .mem_we_i   (mem_fwd_we),
    .mem_rd_i   (mem_fwd_rd),
    .mem_data_i (mem_fwd_data),
    .wb_we_i    (wb_fwd_we),
    .wb_rd_i    (wb_fwd_rd),
    .wb_data_i  (wb_fwd_data),
    .fwd_data_o (rs1_fwd)
  );

  otter_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .addr_i     (rs2_addr_q),
    .regdata_i  (rs2_data_q),
    .mem_we_i   (mem_fwd_we),
    .mem_rd_i   (mem_fwd_rd),
    .mem_data_i (mem_fwd_data),
    .wb_we_i    (wb_fwd_we),
    .wb_rd_i    (wb_fwd_rd),
    .wb_data_i  (wb_fwd_data),
    .fwd_data_o (rs2_fwd)
  );

  always_comb begin
    ALU_srcA = '0;
    case (srcA_sel_q)
      SRCA_RS1:  ALU_srcA = rs1_fwd;
      SRCA_UIMM: ALU_srcA = imm_u_q;
      SRCA_PC:   ALU_srcA = pc_q;
      default:   ALU_srcA = '0;
    endcase
  end

  always_comb begin
    ALU_srcB = '0;
    case (srcB_sel_q)
      SRCB_RS2:  ALU_srcB = rs2_fwd;
      SRCB_IIMM: ALU_srcB = imm_i_q;
      SRCB_SIMM: ALU_srcB = imm_s_q;
      SRCB_PC:   ALU_srcB = pc_q;
      SRCB_FOUR: ALU_srcB = XLEN'(4);
      default:   ALU_srcB = '0;
    endcase
  end

  assign ex_valid   = valid_q;
  assign ALU_FUN    = alu_fun_q;
  assign ex_rs2_fwd = rs2_fwd;
  assign ex_rd_addr = rd_q;
  assign ex_reg_we  = reg_we_q & valid_q;
  assign ex_mem_rd  = mem_rd_q & valid_q;
  assign ex_pc      = pc_q;

endmodule

// File: tb/tb_otter_ex_operand_stage.sv
// Directed bench for the Otter EX operand stage: reset, capture, forwarding priority,
// x0 handling, operand selects, load-use stall/bubble/replay and flush-over-stall.
module tb_otter_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic [31:0] id_imm_u, id_imm_i, id_imm_s;
  logic [1:0]  id_srcA_sel;
  logic [2:0]  id_srcB_sel;
  logic [3:0]  id_alu_fun;
  logic [4:0]  id_rd_addr;
  logic        id_reg_we, id_mem_rd;
  logic        flush;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_we;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        id_stall, ex_valid;
  logic [31:0] ALU_srcA, ALU_srcB, ex_rs2_fwd, ex_pc;
  logic [3:0]  ALU_FUN;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_we, ex_mem_rd;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 CLK = ~CLK;

  otter_ex_operand_stage dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm_u(id_imm_u), .id_imm_i(id_imm_i), .id_imm_s(id_imm_s),
    .id_srcA_sel(id_srcA_sel), .id_srcB_sel(id_srcB_sel), .id_alu_fun(id_alu_fun),
    .id_rd_addr(id_rd_addr), .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
    .flush(flush), .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .id_stall(id_stall), .ex_valid(ex_valid),
    .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .ALU_FUN(ALU_FUN),
    .ex_rs2_fwd(ex_rs2_fwd), .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we),
    .ex_mem_rd(ex_mem_rd), .ex_pc(ex_pc)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [31:0] rs1Data,
                               input logic [4:0] rs2, input logic [31:0] rs2Data,
                               input logic [1:0] selA, input logic [2:0] selB,
                               input logic [3:0] fun, input logic [4:0] rd,
                               input logic we, input logic memRd);
    id_valid    = valid;
    id_pc       = pc;
    id_rs1_addr = rs1;
    id_rs1_data = rs1Data;
    id_rs2_addr = rs2;
    id_rs2_data = rs2Data;
    id_srcA_sel = selA;
    id_srcB_sel = selB;
    id_alu_fun  = fun;
    id_rd_addr  = rd;
    id_reg_we   = we;
    id_mem_rd   = memRd;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0;
    id_imm_u = 32'h0; id_imm_i = 32'h0; id_imm_s = 32'h0;
    mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h0;
    wb_fwd_we = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h0;
    applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 2'd0, 3'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("reset_valid", ex_valid, 0);
    checkOutput("reset_stall", id_stall, 0);

    // Capture a SUB, then hold reset for two cycles while decode keeps presenting it.
    RST = 1'b0;
    applyStimulus(1'b1, 32'h40, 5'd1, 32'h1, 5'd2, 32'h2, 2'd0, 3'd0, 4'b1000, 5'd9, 1'b1, 1'b0);
    tick();
    checkOutput("pre_rst_valid", ex_valid, 1);
    checkOutput("pre_rst_fun", ALU_FUN, 4'b1000);
    RST = 1'b1;
    tick();
    checkOutput("rst_valid", ex_valid, 0);
    checkOutput("rst_fun", ALU_FUN, 0);
    checkOutput("rst_we", ex_reg_we, 0);
    tick();
    checkOutput("rst2_rd", ex_rd_addr, 0);
    RST = 1'b0;

    // add x3, x1, x2 with x1=5, x2=7
    applyStimulus(1'b1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 2'd0, 3'd0, 4'b0000, 5'd3, 1'b1, 1'b0);
    tick();
    checkOutput("add_srcA", ALU_srcA, 5);
    checkOutput("add_srcB", ALU_srcB, 7);
    checkOutput("add_fun", ALU_FUN, 0);
    checkOutput("add_rd", ex_rd_addr, 3);
    checkOutput("add_we", ex_reg_we, 1);
    checkOutput("add_pc", ex_pc, 32'h100);

    // Forwarding priority on rs1=x4 (MEM beats WB, WB beats regfile), srcB = I-imm
    id_imm_i = 32'h123;
    applyStimulus(1'b1, 32'h104, 5'd4, 32'h99, 5'd6, 32'h66, 2'd0, 3'd1, 4'b0110, 5'd7, 1'b1, 1'b0);
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h10;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h20;
    tick();
    checkOutput("fwd_mem", ALU_srcA, 32'h10);
    checkOutput("fwd_srcB_iimm", ALU_srcB, 32'h123);
    checkOutput("fwd_rs2_none", ex_rs2_fwd, 32'h66);
    mem_fwd_we = 1'b0;
    #1;
    checkOutput("fwd_wb", ALU_srcA, 32'h20);
    wb_fwd_rd = 5'd6; wb_fwd_data = 32'h55;
    #1;
    checkOutput("fwd_regfile", ALU_srcA, 32'h99);
    checkOutput("fwd_rs2_wb", ex_rs2_fwd, 32'h55);
    wb_fwd_we = 1'b0;

    // x0 never forwarded; srcB = const 4
    applyStimulus(1'b1, 32'h108, 5'd0, 32'h0, 5'd2, 32'h7, 2'd0, 3'd4, 4'b0000, 5'd8, 1'b1, 1'b0);
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
    tick();
    checkOutput("x0_srcA", ALU_srcA, 0);
    checkOutput("const4_srcB", ALU_srcB, 4);
    mem_fwd_we = 1'b0;

    // srcA=PC, srcB=S-imm; then srcA=zero, srcB undefined code 6
    id_imm_s = 32'hFFFF_FFF8;
    applyStimulus(1'b1, 32'h10C, 5'd1, 32'h5, 5'd2, 32'h7, 2'd2, 3'd2, 4'b0000, 5'd0, 1'b0, 1'b0);
    tick();
    checkOutput("pc_srcA", ALU_srcA, 32'h10C);
    checkOutput("simm_srcB", ALU_srcB, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 32'h110, 5'd1, 32'h5, 5'd2, 32'h7, 2'd3, 3'd6, 4'b0010, 5'd4, 1'b1, 1'b0);
    tick();
    checkOutput("zero_srcA", ALU_srcA, 0);
    checkOutput("undef_srcB", ALU_srcB, 0);
    applyStimulus(1'b1, 32'h114, 5'd1, 32'h5, 5'd2, 32'h7, 2'd0, 3'd3, 4'b0011, 5'd4, 1'b1, 1'b0);
    tick();
    checkOutput("pc_srcB", ALU_srcB, 32'h114);

    // Invalid decode slot: write enable must not leak into EX
    applyStimulus(1'b0, 32'h118, 5'd1, 32'h5, 5'd2, 32'h7, 2'd0, 3'd0, 4'b0000, 5'd4, 1'b1, 1'b1);
    tick();
    checkOutput("inv_valid", ex_valid, 0);
    checkOutput("inv_we", ex_reg_we, 0);
    checkOutput("inv_memrd", ex_mem_rd, 0);

    // lw x5 in EX, then add x6,x5,x2 in decode -> one stall cycle, bubble, replay
    applyStimulus(1'b1, 32'h200, 5'd1, 32'h5, 5'd0, 32'h0, 2'd0, 3'd1, 4'b0000, 5'd5, 1'b1, 1'b1);
    tick();
    checkOutput("lw_memrd", ex_mem_rd, 1);
    applyStimulus(1'b1, 32'h204, 5'd5, 32'h0, 5'd2, 32'h7, 2'd0, 3'd0, 4'b0000, 5'd6, 1'b1, 1'b0);
    #1;
    checkOutput("lu_stall", id_stall, 1);
    tick();
    checkOutput("lu_bubble_valid", ex_valid, 0);
    checkOutput("lu_bubble_we", ex_reg_we, 0);
    checkOutput("lu_bubble_fun", ALU_FUN, 0);
    checkOutput("lu_stall_clear", id_stall, 0);
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h77;
    tick();
    checkOutput("replay_valid", ex_valid, 1);
    checkOutput("replay_rd", ex_rd_addr, 6);
    checkOutput("replay_srcA", ALU_srcA, 32'h77);
    mem_fwd_we = 1'b0;

    // Load to x7 hitting rs2, and a load to x0 which must never stall
    applyStimulus(1'b1, 32'h208, 5'd1, 32'h5, 5'd0, 32'h0, 2'd0, 3'd1, 4'b0000, 5'd7, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h20C, 5'd1, 32'h5, 5'd7, 32'h0, 2'd0, 3'd0, 4'b0000, 5'd8, 1'b1, 1'b0);
    #1;
    checkOutput("lu_rs2_stall", id_stall, 1);
    applyStimulus(1'b1, 32'h210, 5'd1, 32'h5, 5'd0, 32'h0, 2'd0, 3'd1, 4'b0000, 5'd0, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 32'h214, 5'd0, 32'h0, 5'd0, 32'h0, 2'd0, 3'd0, 4'b0000, 5'd8, 1'b1, 1'b0);
    #1;
    checkOutput("x0_load_nostall", id_stall, 0);

    // Flush together with a load-use hazard: flush wins, no stall
    applyStimulus(1'b1, 32'h300, 5'd1, 32'h5, 5'd0, 32'h0, 2'd0, 3'd1, 4'b0000, 5'd5, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h304, 5'd5, 32'h0, 5'd2, 32'h7, 2'd0, 3'd0, 4'b0000, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush_nostall", id_stall, 0);
    tick();
    checkOutput("flush_valid", ex_valid, 0);
    checkOutput("flush_memrd", ex_mem_rd, 0);
    flush = 1'b0;

    // lui x8, 0x12345
    id_imm_u = 32'h1234_5000;
    applyStimulus(1'b1, 32'h308, 5'd0, 32'h0, 5'd0, 32'h0, 2'd1, 3'd0, 4'b1001, 5'd8, 1'b1, 1'b0);
    #1;
    checkOutput("post_flush_nostall", id_stall, 0);
    tick();
    checkOutput("lui_srcA", ALU_srcA, 32'h1234_5000);
    checkOutput("lui_fun", ALU_FUN, 4'b1001);
    checkOutput("lui_valid", ex_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
